// File: rtl/core_pkg.sv
// Shared core types: reorder-buffer depth, index type and per-entry record.
package core_pkg;
    localparam int ROB_ENTRIES = 8;

    typedef logic [$clog2(ROB_ENTRIES)-1:0] rob_idx_t;

    typedef struct packed {
        logic        valid;
        logic        done;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] val;
        logic        mispred;
        logic        exc;
    } rob_entry_t;
endpackage

// File: rtl/execute_reorder_buffer_if.sv
// Completion channel from execute into the reorder buffer.
interface execute_reorder_buffer_if #(
    parameter int IDX_W = 3
);
    logic             ex_valid;
    logic [IDX_W-1:0] rob_entry_idx;
    logic [31:0]      ex_val;
    logic             br_mispred;
    logic             exception;

    modport ex  (output ex_valid, rob_entry_idx, ex_val, br_mispred, exception);
    modport rob (input  ex_valid, rob_entry_idx, ex_val, br_mispred, exception);
endinterface

// File: rtl/rob_ptr.sv
// Circular pointer over a power-of-two ring; the extra MSB is the wrap bit.
module rob_ptr #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inc,
    input  logic                   clr,
    output logic [$clog2(DEPTH):0] ptr
);
    // DEPTH is a power of two, so a plain +1 carries into the wrap bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (clr)
            ptr <= '0;
        else if (inc)
            ptr <= ptr + 1'b1;
    end
endmodule

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: allocates at dispatch, records execute completions,
// retires one entry per cycle and flushes on a retiring mispredict or exception.
module reorder_buffer #(
    parameter int ROB_ENTRIES = core_pkg::ROB_ENTRIES
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           disp_valid,
    input  logic [4:0]                     disp_rd,
    input  logic [31:0]                    disp_pc,
    output logic                           disp_ready,
    output logic [$clog2(ROB_ENTRIES)-1:0] disp_rob_idx,
    input  logic                           ex_valid,
    input  logic [$clog2(ROB_ENTRIES)-1:0] rob_entry_idx,
    input  logic [31:0]                    ex_val,
    input  logic                           br_mispred,
    input  logic                           exception,
    output logic                           commit_valid,
    output logic [4:0]                     commit_rd,
    output logic [31:0]                    commit_val,
    output logic                           flush,
    output logic                           flush_exc,
    output logic [31:0]                    flush_pc
);
    import core_pkg::*;

    localparam int IDX_W = $clog2(ROB_ENTRIES);
    localparam int CNT_W = IDX_W + 1;

    execute_reorder_buffer_if #(.IDX_W(IDX_W)) cpl_if ();

    assign cpl_if.ex_valid      = ex_valid;
    assign cpl_if.rob_entry_idx = rob_entry_idx;
    assign cpl_if.ex_val        = ex_val;
    assign cpl_if.br_mispred    = br_mispred;
    assign cpl_if.exception     = exception;

    rob_entry_t       entries [ROB_ENTRIES];
    logic [IDX_W:0]   head_ptr;
    logic [IDX_W:0]   tail_ptr;
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;
    rob_entry_t       head_entry;
    logic             head_rdy;
    logic             full;
    logic             alloc;
    logic             retire;

    assign head_idx   = head_ptr[IDX_W-1:0];
    assign tail_idx   = tail_ptr[IDX_W-1:0];
    assign head_entry = entries[head_idx];

    // With wrap bits the pointer difference is the exact occupancy (0..ROB_ENTRIES).
    assign count = tail_ptr - head_ptr;
    assign full  = (count == CNT_W'(ROB_ENTRIES));

    assign head_rdy     = head_entry.valid && head_entry.done;
    assign flush        = head_rdy && (head_entry.mispred || head_entry.exc);
    assign commit_valid = head_rdy && !head_entry.exc;
    assign commit_rd    = head_entry.rd;
    assign commit_val   = head_entry.val;
    assign flush_exc    = head_entry.exc;
    assign flush_pc     = head_entry.pc;

    assign disp_ready   = !full && !flush;
    assign disp_rob_idx = tail_idx;
    assign alloc        = disp_valid && disp_ready;
    assign retire       = head_rdy && !flush;

    rob_ptr #(.DEPTH(ROB_ENTRIES)) u_head_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (retire),
        .clr   (flush),
        .ptr   (head_ptr)
    );

    rob_ptr #(.DEPTH(ROB_ENTRIES)) u_tail_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (alloc),
        .clr   (flush),
        .ptr   (tail_ptr)
    );

    // Payloads survive a flush; only valid bits are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROB_ENTRIES; i++)
                entries[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < ROB_ENTRIES; i++)
                entries[i].valid <= 1'b0;
        end else begin
            if (cpl_if.ex_valid && entries[cpl_if.rob_entry_idx].valid) begin
                entries[cpl_if.rob_entry_idx].done    <= 1'b1;
                entries[cpl_if.rob_entry_idx].val     <= cpl_if.ex_val;
                entries[cpl_if.rob_entry_idx].mispred <= cpl_if.br_mispred;
                entries[cpl_if.rob_entry_idx].exc     <= cpl_if.exception;
            end
            if (retire)
                entries[head_idx].valid <= 1'b0;
            if (alloc) begin
                entries[tail_idx].valid   <= 1'b1;
                entries[tail_idx].done    <= 1'b0;
                entries[tail_idx].rd      <= disp_rd;
                entries[tail_idx].pc      <= disp_pc;
                entries[tail_idx].mispred <= 1'b0;
                entries[tail_idx].exc     <= 1'b0;
            end
        end
    end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

- In-order reorder buffer at the receiving end of the execute→ROB completion channel.
- Allocates one entry per dispatched instruction and records completion results, branch-mispredict and exception flags from execute.
- Retires one instruction per cycle in program order.
- On retiring an instruction flagged mispredict or exception, asserts a one-cycle flush and empties itself.

## Interface
Parameters:
- ROB_ENTRIES, default CORE_PKG::ROB_ENTRIES (8): entry count; power of two, ≥2.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- disp_valid  in  1  dispatch requests an entry this cycle.
- disp_rd  in  5  destination register of the dispatched instruction.
- disp_pc  in  32  PC of the dispatched instruction.
- disp_ready  out  1  an entry is available; allocation occurs when disp_valid && disp_ready.
- disp_rob_idx  out  $clog2(ROB_ENTRIES)  index the dispatched instruction receives (current tail).
- ex_valid  in  1  execute completion valid.
- rob_entry_idx  in  $clog2(ROB_ENTRIES)  entry being completed.
- ex_val  in  32  result value.
- br_mispred  in  1  completed instruction is a mispredicted branch.
- exception  in  1  completed instruction raised an exception.
- commit_valid  out  1  head instruction retires this cycle; write commit_val to commit_rd.
- commit_rd  out  5  destination register of the retiring instruction.
- commit_val  out  32  result of the retiring instruction.
- flush  out  1  pipeline flush; one cycle.
- flush_exc  out  1  flush cause: 1 = exception, 0 = mispredict.
- flush_pc  out  32  PC of the instruction causing the flush.

## Operation
- State:
  - Per-entry fields: valid, done, rd, pc, val, mispred, exc.
  - head and tail pointers with an extra wrap bit.
  - count (0..ROB_ENTRIES).
- Full/empty:
  - full = (count == ROB_ENTRIES).
  - empty = (count == 0).
  - Pointer wrap from ROB_ENTRIES-1 to 0 toggles the wrap bit.
- Dispatch:
  - disp_ready = !full && !flush, computed from current-cycle state.
  - A commit in the same cycle does not free a slot for dispatch in that cycle.
  - On allocate, entry[tail] is loaded with valid=1, done=0, rd, pc, mispred=0, exc=0, and tail increments.
- Completion:
  - When ex_valid, and entry[rob_entry_idx] is valid using pre-edge state, the entry is loaded with done=1, val=ex_val, mispred=br_mispred, exc=exception.
  - Completion to an invalid entry is ignored.
  - Completion in a flush cycle is ignored.
- Retire:
  - head_rdy = entry[head].valid && entry[head].done.
  - commit_valid = head_rdy && !entry[head].exc.
  - flush = head_rdy && (entry[head].mispred || entry[head].exc).
  - flush_exc = entry[head].exc; flush_pc = entry[head].pc.
  - commit_rd and commit_val always show the head entry.
  - On head_rdy without flush: entry[head].valid cleared, head increments.
- Flush:
  - At the next edge, all valid bits are cleared, head = tail = 0, count = 0.
  - A mispredicted branch still commits its rd (e.g. JAL/JALR link); an exception instruction does not.
- Count: count_next = count + alloc − retire. Simultaneous alloc and retire leave count unchanged.
- Reset:
  - All valid bits cleared; pointers and count = 0.
  - Outputs at reset: disp_ready=1, disp_rob_idx=0, commit_valid=0, flush=0, flush_exc=0, flush_pc=0, commit_rd=0, commit_val=0.
  - Reset mid-operation discards all entries immediately; no flush pulse.

## Timing
- Allocation visible at the edge after disp_valid && disp_ready.
- Completion write is registered. commit_valid or flush for that entry is asserted combinationally in the following cycle, so completion-to-retire latency is 1 cycle minimum.
- Throughput: 1 dispatch + 1 completion + 1 retire per cycle.
- flush is a single-cycle pulse. disp_ready is 0 during that cycle and returns to 1 the cycle after.

## Structure
- CORE_PKG holds:
  - ROB_ENTRIES.
  - rob_idx_t = logic [$clog2(ROB_ENTRIES)-1:0].
  - rob_entry_t struct {valid, done, rd, pc, val, mispred, exc}.
- Module connects through execute_reorder_buffer_if (rob modport) for the completion ports.
- One sub-module: rob_ptr, a wrapping pointer with wrap bit, with increment and clear inputs. Instantiated for head and tail.

## Test plan
- Reset → disp_ready=1, disp_rob_idx=0, commit_valid=0, flush=0.
- Dispatch 3 instrs (rd=1,2,3); complete idx 2, then 0, then 1 with ex_val 0x30, 0x10, 0x20 → commits in order rd1=0x10, rd2=0x20, rd3=0x30, each the cycle after its last dependency completes.
- Dispatch 8 with no completions → disp_ready=0 after the 8th. Dispatch attempt while full is dropped. Complete and commit idx 0 → disp_ready=1 the next cycle; the new entry gets idx 0 (wrap).
- Dispatch 4, complete idx 1 with br_mispred=1, ex_val=0x44, complete idx 0 → commit idx0, then commit_valid=1 and flush=1 with flush_exc=0 and flush_pc=pc1 for idx1. Next cycle count=0 and disp_rob_idx=0.
- Complete head with exception=1 → commit_valid=0, flush=1, flush_exc=1. A completion to idx2 in the same cycle is ignored and nothing commits afterwards.
- Assert rst_n low while 5 entries are in flight → outputs return to reset values asynchronously, with no flush pulse.
